// File: rtl/rsa_job_arbiter.sv
// rsa_job_arbiter: shares one modular-exponentiation engine between two
// requesters. Jobs are granted round-robin, issued to the engine with a
// one-cycle start pulse, and answered with a one-cycle response carrying
// the owner id, the result and an error flag (reject for N<2, or watchdog
// timeout).
module rsa_job_arbiter #(
  parameter int n       = 6,
  parameter int TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [n-1:0] req0_base,
  input  logic [n-1:0] req0_key,
  input  logic [n-1:0] req0_n,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [n-1:0] req1_base,
  input  logic [n-1:0] req1_key,
  input  logic [n-1:0] req1_n,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [n-1:0] rsp_result,
  output logic         rsp_err,
  output logic         busy,
  output logic         eng_start,
  output logic [n-1:0] eng_base,
  output logic [n-1:0] eng_key,
  output logic [n-1:0] eng_n,
  input  logic [n-1:0] eng_result,
  input  logic         eng_done,
  output logic         eng_abort
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT - 1);

  state_t         state, state_nx;
  logic           last_grant;
  logic           grant;
  logic           accept;
  logic           reject;
  logic           expired;
  logic [15:0]    wdog;
  logic [n-1:0]   sel_base, sel_key, sel_n;

  // Round-robin grant and operand mux for the requester that would be accepted.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
    sel_base   = grant ? req1_base : req0_base;
    sel_key    = grant ? req1_key  : req0_key;
    sel_n      = grant ? req1_n    : req0_n;
    req0_ready = (state == IDLE) && req0_valid && !grant;
    req1_ready = (state == IDLE) && req1_valid &&  grant;
    accept     = req0_ready || req1_ready;
    reject     = (sel_n[n-1:1] == '0);   // modulus 0 or 1
    expired    = (wdog == WDOG_LAST);
  end

  // Next-state logic and the one-cycle control pulses.
  always_comb begin
    state_nx  = state;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    rsp_valid = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (accept) state_nx = reject ? RESP : ISSUE;
      end
      ISSUE: begin
        eng_start = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (eng_done) begin
          state_nx = RESP;
        end else if (expired) begin
          // A job being wiped by reset must not abort the engine.
          eng_abort = !rst;
          state_nx  = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // State, arbitration history, watchdog, operand and response registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (rst) begin
      // NOTE: all datapath registers are cleared too, not just control, so
      // the operand and response outputs read 0 straight out of reset.
      state      <= IDLE;
      last_grant <= 1'b1;
      wdog       <= '0;
      eng_base   <= '0;
      eng_key    <= '0;
      eng_n      <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            eng_base   <= sel_base;
            eng_key    <= sel_key;
            eng_n      <= sel_n;
            rsp_id     <= grant;
            last_grant <= grant;
            rsp_result <= '0;
            rsp_err    <= reject;
          end
        end
        ISSUE: wdog <= '0;
        WAIT: begin
          wdog <= wdog + 16'd1;
          if (eng_done) begin
            rsp_result <= eng_result;
            rsp_err    <= 1'b0;
          end else if (expired) begin
            rsp_result <= '0;
            rsp_err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed bench for rsa_job_arbiter with a behavioural engine whose done
// delay is programmable (0 = never completes).
module tb_rsa_job_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [5:0] req0_base, req0_key, req0_n;
  logic [5:0] req1_base, req1_key, req1_n;
  logic       rsp_valid, rsp_id, rsp_err, busy;
  logic [5:0] rsp_result;
  logic       eng_start, eng_done, eng_abort;
  logic [5:0] eng_base, eng_key, eng_n, eng_result;

  int vectors     = 0;
  int miscompares = 0;

  rsa_job_arbiter #(.n(6), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_base(req0_base), .req0_key(req0_key), .req0_n(req0_n),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_base(req1_base), .req1_key(req1_key), .req1_n(req1_n),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_err(rsp_err), .busy(busy),
    .eng_start(eng_start), .eng_base(eng_base), .eng_key(eng_key),
    .eng_n(eng_n), .eng_result(eng_result), .eng_done(eng_done),
    .eng_abort(eng_abort)
  );

  always #5 clk = ~clk;

  // Behavioural engine: done arrives eng_delay cycles after the start cycle.
  int         eng_delay   = 0;
  logic       stray_done  = 1'b0;
  logic       model_active = 1'b0;
  int         model_cnt   = 0;
  logic [5:0] model_res   = '0;
  logic       model_hit;

  function automatic logic [5:0] modexp(input logic [5:0] b, input logic [5:0] k,
                                        input logic [5:0] m);
    int r, x;
    if (m < 6'd2) return 6'd0;
    r = 1;
    x = int'(b) % int'(m);
    for (int i = 0; i < 6; i++) begin
      if (k[i]) r = (r * x) % int'(m);
      x = (x * x) % int'(m);
    end
    return 6'(r);
  endfunction

  assign model_hit  = model_active && (eng_delay != 0) && (model_cnt == eng_delay);
  assign eng_done   = model_hit || stray_done;
  assign eng_result = stray_done ? 6'd42 : model_res;

  always @(posedge clk) begin
    if (eng_start) begin
      model_active <= 1'b1;
      model_cnt    <= 1;
      model_res    <= modexp(eng_base, eng_key, eng_n);
    end else if (model_active) begin
      if (model_hit) model_active <= 1'b0;
      else           model_cnt    <= model_cnt + 1;
    end
  end

  // Event counters for pulses that must (not) happen inside a window.
  int start_count = 0, abort_count = 0, rsp_count = 0;
  always @(posedge clk) begin
    if (eng_start) start_count++;
    if (eng_abort) abort_count++;
    if (rsp_valid) rsp_count++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_rsp(input int limit, output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < limit) begin
      step();
      cycles++;
      if (rsp_valid === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    vectors++;
    if ({busy, rsp_valid, eng_start, eng_abort, req0_ready, req1_ready} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {busy, rsp_valid, eng_start, eng_abort, req0_ready, req1_ready});
    end
    vectors++;
    if ({eng_base, eng_key, eng_n, rsp_result, rsp_id, rsp_err} !== 26'd0) begin
      miscompares++;
      $display("FAIL reset_regs got=%h want=0",
               {eng_base, eng_key, eng_n, rsp_result, rsp_id, rsp_err});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    int cyc;
    bit seen;
    eng_delay = 3;
    req0_base = 6'd3; req0_key = 6'd15; req0_n = 6'd2; req0_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL t1_ready got=%b want=10", {req0_ready, req1_ready});
    end
    step();
    req0_valid = 1'b0;
    vectors++;
    if ({eng_start, busy} !== 2'b11) begin
      miscompares++;
      $display("FAIL t1_start got=%b want=11", {eng_start, busy});
    end
    vectors++;
    if ({eng_base, eng_key, eng_n} !== {6'd3, 6'd15, 6'd2}) begin
      miscompares++;
      $display("FAIL t1_operands got=%h want=%h", {eng_base, eng_key, eng_n},
               {6'd3, 6'd15, 6'd2});
    end
    wait_rsp(20, cyc, seen);
    vectors++;
    if (!seen || cyc != 4) begin
      miscompares++;
      $display("FAIL t1_latency got seen=%0d cycles=%0d want seen=1 cycles=4", seen, cyc);
    end
    vectors++;
    if ({rsp_id, rsp_result, rsp_err} !== {1'b0, 6'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL t1_rsp got id=%b res=%0d err=%b want id=0 res=1 err=0",
               rsp_id, rsp_result, rsp_err);
    end
    step();
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL t1_idle got=%b want=00", {rsp_valid, busy});
    end
  endtask

  task automatic test_round_robin();
    int cyc;
    bit seen;
    logic [5:0] exp_res;
    rst = 1'b1;
    step();
    rst = 1'b0;
    eng_delay = 1;
    req0_base = 6'd3;  req0_key = 6'd15; req0_n = 6'd2;
    req1_base = 6'd50; req1_key = 6'd6;  req1_n = 6'd35;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("FAIL t2_first_grant got=%b want=10", {req0_ready, req1_ready});
    end
    for (int i = 0; i < 4; i++) begin
      wait_rsp(20, cyc, seen);
      if (i == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
      exp_res = (i % 2 == 0) ? 6'd1 : 6'd15;
      vectors++;
      if (!seen || (i > 0 && cyc != 4)) begin
        miscompares++;
        $display("FAIL t2_spacing[%0d] got seen=%0d cycles=%0d want 4", i, seen, cyc);
      end
      vectors++;
      if ({rsp_id, rsp_result, rsp_err} !== {1'(i % 2), exp_res, 1'b0}) begin
        miscompares++;
        $display("FAIL t2_rsp[%0d] got id=%b res=%0d err=%b want id=%0d res=%0d err=0",
                 i, rsp_id, rsp_result, rsp_err, i % 2, exp_res);
      end
    end
    step();
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t2_idle got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reject();
    int sc;
    sc = start_count;
    req1_base = 6'd5; req1_key = 6'd3; req1_n = 6'd1; req1_valid = 1'b1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL t3_ready got=%b want=01", {req0_ready, req1_ready});
    end
    step();
    req1_valid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err, eng_start} !== 4'b1110 || rsp_result !== 6'd0) begin
      miscompares++;
      $display("FAIL t3_rsp got v/id/err/start=%b res=%0d want 1110 res=0",
               {rsp_valid, rsp_id, rsp_err, eng_start}, rsp_result);
    end
    step();
    vectors++;
    if ({busy, rsp_valid} !== 2'b00 || start_count != sc) begin
      miscompares++;
      $display("FAIL t3_no_start got busy/v=%b starts=%0d want 00 starts=%0d",
               {busy, rsp_valid}, start_count, sc);
    end
  endtask

  task automatic test_timeout();
    int cyc, ac;
    bit seen;
    ac = abort_count;
    eng_delay = 0;
    req0_base = 6'd7; req0_key = 6'd5; req0_n = 6'd11; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      step();
      cyc++;
      if (eng_abort === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || cyc != 8 || rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_abort got seen=%0d cycles=%0d rsp_valid=%b want 1/8/0",
               seen, cyc, rsp_valid);
    end
    step();
    vectors++;
    if ({rsp_valid, rsp_id, rsp_err} !== 3'b101 || rsp_result !== 6'd0) begin
      miscompares++;
      $display("FAIL t4_timeout_rsp got v/id/err=%b res=%0d want 101 res=0",
               {rsp_valid, rsp_id, rsp_err}, rsp_result);
    end
    step();
    // Done lands exactly on the expiry cycle: done must win.
    eng_delay = 8;
    req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      step();
      cyc++;
      if (eng_done === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (!seen || cyc != 8 || eng_abort !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_done_on_expiry got seen=%0d cycles=%0d abort=%b want 1/8/0",
               seen, cyc, eng_abort);
    end
    step();
    vectors++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_result !== 6'd10 || abort_count != ac + 1) begin
      miscompares++;
      $display("FAIL t4_done_rsp got v/err=%b res=%0d aborts=%0d want 10 res=10 aborts=%0d",
               {rsp_valid, rsp_err}, rsp_result, abort_count, ac + 1);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int rc, ac, cyc;
    bit seen;
    eng_delay = 6;
    req1_base = 6'd2; req1_key = 6'd5; req1_n = 6'd13; req1_valid = 1'b1;
    step();
    req1_valid = 1'b0;
    step();
    step();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL t5_in_wait got busy=%b want 1", busy);
    end
    rc = rsp_count;
    ac = abort_count;
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || {eng_base, eng_key, eng_n} !== 18'd0) begin
      miscompares++;
      $display("FAIL t5_reset got busy=%b ops=%h want 0 ops=0", busy,
               {eng_base, eng_key, eng_n});
    end
    repeat (10) step();
    vectors++;
    if (rsp_count != rc || abort_count != ac || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_lost_job got rsps=%0d aborts=%0d busy=%b want %0d/%0d/0",
               rsp_count, abort_count, busy, rc, ac);
    end
    eng_delay = 2;
    req0_base = 6'd3; req0_key = 6'd4; req0_n = 6'd7; req0_valid = 1'b1;
    step();
    req0_valid = 1'b0;
    wait_rsp(20, cyc, seen);
    vectors++;
    if (!seen || cyc != 3 || {rsp_id, rsp_err} !== 2'b00 || rsp_result !== 6'd4) begin
      miscompares++;
      $display("FAIL t5_next_job got seen=%0d cycles=%0d id/err=%b res=%0d want 1/3/00/4",
               seen, cyc, {rsp_id, rsp_err}, rsp_result);
    end
    step();
  endtask

  task automatic test_stray_done();
    int rc;
    rc = rsp_count;
    stray_done = 1'b1;
    step();
    stray_done = 1'b0;
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL t6_no_rsp got v/busy=%b want 00", {rsp_valid, busy});
    end
    step();
    vectors++;
    if (rsp_count != rc || rsp_result !== 6'd4 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL t6_state got rsps=%0d res=%0d busy=%b want %0d/4/0",
               rsp_count, rsp_result, busy, rc);
    end
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_base = '0; req0_key = '0; req0_n = '0;
    req1_base = '0; req1_key = '0; req1_n = '0;
    step();
    test_reset();
    test_single_job();
    test_round_robin();
    test_reject();
    test_timeout();
    test_reset_mid_wait();
    test_stray_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion want finish before 200000");
    $fatal(1, "simulation time limit reached");
  end

endmodule
